// File: rtl/reg_access_seq.sv
// Operand-fetch / writeback sequencer in front of a 16-entry register file.
// Tracks outstanding writebacks in a busy scoreboard so operands are never read stale.
module reg_access_seq #(
  parameter int N = 19,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [M:0]   op_s0,
  input  logic [M:0]   op_s1,
  input  logic [M:0]   op_dest,
  input  logic         op_wr,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [N:0]   rd_a,
  output logic [N:0]   rd_b,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [M:0]   wb_addr,
  input  logic [N:0]   wb_data,
  output logic [N:0]   rf_in,
  output logic [M:0]   rf_dest,
  output logic [M:0]   rf_s0,
  output logic [M:0]   rf_s1,
  output logic         rf_s0_en,
  output logic         rf_s1_en,
  input  logic [N:0]   rf_o1,
  input  logic [N:0]   rf_o2
);

  localparam int REGS = 2 ** (M + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state, state_nxt;
  logic [REGS-1:0] busy, busy_eff, busy_nxt;
  logic            op_accept;

  assign wb_ready = 1'b1;

  // A writeback landing this cycle frees its register for an op accepted on the same edge.
  always_comb begin
    busy_eff = busy;
    if (wb_valid)
      busy_eff[wb_addr] = 1'b0;
  end

  always_comb begin
    op_ready  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        op_ready = rst_n && !busy_eff[op_s0] && !busy_eff[op_s1] &&
                   !(op_wr && busy_eff[op_dest]);
        if (op_valid && op_ready)
          state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (rd_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign op_accept = op_valid && op_ready;

  // Set wins over clear when both hit the same index on one edge.
  always_comb begin
    busy_nxt = busy_eff;
    if (op_accept && op_wr)
      busy_nxt[op_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
    end
  end

  // rf_s1_en doubles as the file's write enable, so it also fires for the ISSUE read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_s0_en <= 1'b0;
      rf_s1_en <= 1'b0;
      rf_s0    <= '0;
      rf_s1    <= '0;
      rf_dest  <= '0;
      rf_in    <= '0;
    end else begin
      rf_s0_en <= op_accept;
      rf_s1_en <= op_accept || wb_valid;
      if (op_accept) begin
        rf_s0 <= op_s0;
        rf_s1 <= op_s1;
      end
      if (wb_valid) begin
        rf_dest <= wb_addr;
        rf_in   <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_a     <= '0;
      rd_b     <= '0;
    end else if (state == CAPTURE) begin
      rd_valid <= 1'b1;
      rd_a     <= rf_o1;
      rd_b     <= rf_o2;
    end else if (state == RESP && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// Bench for reg_access_seq: behavioural register file, architectural model and response queue.
module tb_reg_access_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0, op_ready, op_wr = 1'b0;
  logic [3:0]  op_s0 = '0, op_s1 = '0, op_dest = '0;
  logic        rd_valid, rd_ready = 1'b1;
  logic [19:0] rd_a, rd_b;
  logic        wb_valid = 1'b0, wb_ready;
  logic [3:0]  wb_addr = '0;
  logic [19:0] wb_data = '0;
  logic [19:0] rf_in;
  logic [3:0]  rf_dest, rf_s0, rf_s1;
  logic        rf_s0_en, rf_s1_en;
  logic [19:0] rf_o1 = '0, rf_o2 = '0;

  logic [19:0] regs [16];
  logic [19:0] model [16];
  int          errors = 0;
  int          checks = 0;
  longint      t_acc, t1, t2;

  typedef struct packed {
    logic [19:0] a;
    logic [19:0] b;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_access_seq dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_s0(op_s0), .op_s1(op_s1), .op_dest(op_dest), .op_wr(op_wr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_a(rd_a), .rd_b(rd_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_in(rf_in), .rf_dest(rf_dest), .rf_s0(rf_s0), .rf_s1(rf_s1),
    .rf_s0_en(rf_s0_en), .rf_s1_en(rf_s1_en), .rf_o1(rf_o1), .rf_o2(rf_o2)
  );

  // Register file: registered reads on posedge, write on the negedge of an rf_s1_en cycle.
  always @(posedge clk) begin
    if (rf_s0_en) rf_o1 <= regs[rf_s0];
    if (rf_s1_en) rf_o2 <= regs[rf_s1];
  end

  always @(negedge clk) begin
    if (rf_s1_en) regs[rf_dest] <= rf_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_n && rd_valid && rd_ready) begin
      chk("rsp_queue_nonempty", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_a", rd_a, e.a);
        chk("rsp_b", rd_b, e.b);
      end
    end
  end

  task automatic drive_op(input logic [3:0] s0, input logic [3:0] s1,
                          input logic [3:0] dest, input logic wr);
    op_valid = 1'b1;
    op_s0    = s0;
    op_s1    = s1;
    op_dest  = dest;
    op_wr    = wr;
  endtask

  task automatic drive_wb(input logic [3:0] a, input logic [19:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    model[a] = d;
  endtask

  task automatic push_exp();
    exp_t e;
    e.a = model[op_s0];
    e.b = model[op_s1];
    exp_q.push_back(e);
  endtask

  // Called on the accept edge; returns in the first RESP cycle.
  task automatic finish_op(input logic [3:0] s0, input logic [3:0] s1);
    @(negedge clk);
    op_valid = 1'b0;
    wb_valid = 1'b0;
    #1;
    chk("issue_s0_en", rf_s0_en, 1);
    chk("issue_s1_en", rf_s1_en, 1);
    chk("issue_s0", rf_s0, s0);
    chk("issue_s1", rf_s1, s1);
    chk("issue_vld", rd_valid, 0);
    chk("issue_ready", op_ready, 0);
    @(negedge clk); #1;
    chk("cap_s0_en", rf_s0_en, 0);
    chk("cap_vld", rd_valid, 0);
    @(negedge clk); #1;
    chk("resp_vld", rd_valid, 1);
  endtask

  task automatic run_op(input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] dest, input logic wr);
    drive_op(s0, s1, dest, wr);
    #1;
    chk("op_ready", op_ready, 1);
    push_exp();
    @(posedge clk);
    t_acc = $time;
    finish_op(s0, s1);
    @(negedge clk); #1;
    chk("rsp_done", rd_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      regs[i]  = '0;
      model[i] = '0;
    end

    // Reset state
    @(posedge clk); #1;
    chk("rst_op_ready", op_ready, 0);
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_a", rd_a, 0);
    chk("rst_rd_b", rd_b, 0);
    chk("rst_rf_s0_en", rf_s0_en, 0);
    chk("rst_rf_s1_en", rf_s1_en, 0);
    chk("rst_rf_in", rf_in, 0);
    chk("rst_rf_dest", rf_dest, 0);
    chk("rst_rf_s0", rf_s0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_op_ready", op_ready, 1);

    // Writeback then read it back
    @(negedge clk);
    drive_wb(4'd3, 20'h12345);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("wb_s1_en", rf_s1_en, 1);
    chk("wb_dest", rf_dest, 3);
    chk("wb_in", rf_in, 20'h12345);
    @(negedge clk); #1;
    chk("wb_pulse_end", rf_s1_en, 0);
    run_op(4'd3, 4'd0, 4'd0, 1'b0);

    // Busy hazard held until the writeback arrives
    run_op(4'd1, 4'd2, 4'd5, 1'b1);
    drive_op(4'd5, 4'd1, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_ready", op_ready, 0);
      @(negedge clk);
    end
    drive_wb(4'd5, 20'hABCDE);
    #1;
    chk("wb_release_ready", op_ready, 1);
    push_exp();
    @(posedge clk);
    finish_op(4'd5, 4'd1);
    @(negedge clk); #1;

    // Same-edge op accept and writeback to the source register
    drive_op(4'd7, 4'd7, 4'd0, 1'b0);
    drive_wb(4'd7, 20'h00F0F);
    #1;
    chk("same_edge_ready", op_ready, 1);
    push_exp();
    @(posedge clk);
    finish_op(4'd7, 4'd7);
    @(negedge clk); #1;

    // Response stall with writeback traffic
    rd_ready = 1'b0;
    drive_op(4'd3, 4'd7, 4'd0, 1'b0);
    #1;
    chk("stall_accept", op_ready, 1);
    push_exp();
    @(posedge clk);
    finish_op(4'd3, 4'd7);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_wb(4'(i), 20'h50000 + 20'(i));
      else wb_valid = 1'b0;
      #1;
      chk("stall_vld", rd_valid, 1);
      chk("stall_a", rd_a, 20'h12345);
      chk("stall_b", rd_b, 20'h00F0F);
      chk("stall_ready", op_ready, 0);
      @(negedge clk);
    end
    wb_valid = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk); #1;
    chk("stall_release", rd_valid, 0);
    run_op(4'd10, 4'd3, 4'd0, 1'b0);
    t1 = t_acc;
    run_op(4'd0, 4'd2, 4'd0, 1'b0);
    t2 = t_acc;
    chk("op_period", 32'(t2 - t1), 40);

    // Back-to-back writebacks to every register, then full readback
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive_wb(4'(i), 20'(i * 32'h11111));
      #1;
      chk("sweep_ready", op_ready, 1);
      if (i > 0) begin
        chk("sweep_s1_en", rf_s1_en, 1);
        chk("sweep_dest", rf_dest, 32'(i - 1));
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    #1;
    chk("sweep_last_en", rf_s1_en, 1);
    chk("sweep_last_dest", rf_dest, 15);
    @(negedge clk); #1;
    chk("sweep_end", rf_s1_en, 0);
    for (int j = 0; j < 8; j++)
      run_op(4'(2 * j), 4'(2 * j + 1), 4'd0, 1'b0);

    // Reset during CAPTURE
    drive_op(4'd4, 4'd6, 4'd9, 1'b1);
    #1;
    chk("pre_rst_accept", op_ready, 1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_cap", rf_s0_en, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", rd_valid, 0);
    chk("mid_rst_ready", op_ready, 0);
    chk("mid_rst_s1_en", rf_s1_en, 0);
    chk("mid_rst_wb_ready", wb_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("post_rst_s1_en", rf_s1_en, 0);
      chk("post_rst_vld", rd_valid, 0);
    end
    run_op(4'd9, 4'd4, 4'd0, 1'b0);

    @(negedge clk);
    @(negedge clk); #4;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_access_seq.md
Name: reg_access_seq

Overview:
- Initiator-side sequencer that drives the 16-entry register file's read and write port signals.
- Accepts operand-fetch requests, issues both register reads, captures the registered read data and returns it through a valid/ready response.
- Accepts writeback requests and turns each one into a register-file write.
- Keeps a 16-bit busy scoreboard so an operand is never read while an older, still-outstanding writeback targets its register.

Parameters:
- N, 19: data MSB index; data width is N+1.
- M, 3: register-address MSB index; the file has 2^(M+1) = 16 registers.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand request valid.
- op_ready  out  1  operand request accepted when op_valid and op_ready are both 1 at a posedge.
- op_s0, op_s1  in  M+1  source register addresses.
- op_dest  in  M+1  destination register address of the requesting instruction.
- op_wr  in  1  1 = instruction will write op_dest later (marks it busy).
- rd_valid  out  1  operand response valid.
- rd_ready  in  1  operand response consumed.
- rd_a, rd_b  out  N+1  operand values for s0 and s1.
- wb_valid  in  1  writeback request valid.
- wb_ready  out  1  tied to 1; one writeback per cycle.
- wb_addr  in  M+1  writeback register address.
- wb_data  in  N+1  writeback data.
- rf_in  out  N+1  register file write data.
- rf_dest  out  M+1  register file write address.
- rf_s0, rf_s1  out  M+1  register file read addresses.
- rf_s0_en  out  1  register file read-port-0 enable.
- rf_s1_en  out  1  register file read-port-1 enable; also the file's write enable.
- rf_o1, rf_o2  in  N+1  register file registered read outputs.

Behaviour:
- Register-file timing:
  - Reads are captured on the posedge that ends a cycle in which the enable is high.
  - A write occurs on the negedge inside a cycle with rf_s1_en=1.
  - A read and a write in the same cycle therefore return the new value.
- All rf_* outputs are registered.
- Reset (async, rst_n=0) values:
  - state=IDLE, busy=0, all outputs 0 (rd_a, rd_b, rf_* included).
  - Exceptions: op_ready=0 during reset; wb_ready=1.
  - A reset mid-operation drops the in-flight op and any pending write. No rf_s1_en pulse follows reset release.
- FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
  - IDLE: op_ready = 1 when busy_eff[op_s0], busy_eff[op_s1] and (op_wr & busy_eff[op_dest]) are all 0.
    - busy_eff = busy with bit wb_addr cleared when wb_valid=1.
    - On accept: latch op_s0/op_s1, then go to ISSUE.
  - ISSUE: rf_s0=op_s0, rf_s1=op_s1, rf_s0_en=1, rf_s1_en=1. Next state is CAPTURE.
  - CAPTURE: rf_s0_en=0. At the ending posedge, rd_a<=rf_o1, rd_b<=rf_o2, rd_valid<=1. Next state is RESP.
  - RESP: rd_valid=1 and rd_a/rd_b held stable until rd_ready=1. On that edge rd_valid<=0 and the next state is IDLE.
  - op_ready=0 in every state except IDLE.
- Latency and throughput:
  - Latency is 3 posedges from the accept edge to rd_valid=1.
  - Minimum op period is 4 cycles with rd_ready held at 1.
- Writeback:
  - Accepted every cycle in any state.
  - Each wb accepted at edge E drives rf_dest=wb_addr, rf_in=wb_data and rf_s1_en=1 for exactly the cycle after E.
  - rf_s1 keeps its last value during a write-only cycle.
- During CAPTURE, a write changes rf_o2 only at the edge where rd_b samples. rd_b therefore takes the pre-edge (correct) value.
- Scoreboard:
  - Op accept with op_wr=1 sets busy[op_dest].
  - wb accept clears busy[wb_addr].
  - If the same edge both sets and clears the same index, set wins.
  - A wb to a non-busy register still writes and leaves busy unchanged.
- Simultaneous op accept and wb_addr==op_s0 in IDLE: the op is accepted. The write occurs in ISSUE, so the read returns wb_data.
- All address indexing wraps naturally within M+1 bits; there are no out-of-range addresses.

Test Plan:
- Reset, then wb (addr=3, data=0x12345). Op (s0=3, s1=0, op_wr=0) -> rf_s1_en pulses 1 cycle with rf_dest=3; rd_valid 3 edges after accept; rd_a=0x12345, rd_b=0.
- Op (s0=1, s1=2, dest=5, op_wr=1) completes. Op (s0=5, s1=1) is held with op_ready=0 for 10 cycles. Wb (addr=5, data=0xABCDE) -> op_ready rises that cycle; response rd_a=0xABCDE.
- Same-edge op (s0=7, s1=7) and wb (addr=7, data=0x00F0F) -> rd_a=rd_b=0x00F0F.
- rd_ready held 0 for 5 cycles in RESP, with wb traffic to regs 0-3 -> rd_a/rd_b unchanged, op_ready stays 0; one op per 4 cycles once rd_ready=1.
- Wb to every register 0-15 on back-to-back cycles -> 16 consecutive rf_s1_en cycles; full readback matches; busy stays 0.
- rst_n=0 asserted in CAPTURE -> rd_valid=0 and busy=0 immediately; no rf_s1_en after release; next op reads the previously written values.
